// File: rtl/wb_stage_ldx.sv
// Writeback stage: retires ALU results and aligns/extends returning load data onto the RF write port.
// Latency: ALU result writes 1 cycle after capture, load 1 cycle after mem_rvalid; in_allow drops while a load waits.
module wb_stage_ldx #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    output logic                          in_allow,
    input  logic [31:0]                   in_pc,
    input  logic                          in_rf_we,
    input  logic [RADDR_W-1:0]            in_rf_waddr,
    input  logic [DATA_W-1:0]             in_alu_result,
    input  logic                          in_is_load,
    input  logic [1:0]                    in_ld_size,
    input  logic                          in_ld_unsigned,
    input  logic [$clog2(DATA_W/8)-1:0]   in_addr_lo,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          rf_we,
    output logic [RADDR_W-1:0]            rf_waddr,
    output logic [DATA_W-1:0]             rf_wdata,
    output logic                          byp_valid,
    output logic [RADDR_W-1:0]            byp_waddr,
    output logic [DATA_W-1:0]             byp_wdata,
    output logic                          byp_busy,
    output logic                          err_misalign,
    output logic                          err_timeout,
    output logic                          err_spurious,
    output logic [31:0]                   debug_wb_pc,
    output logic [3:0]                    debug_wb_rf_wen,
    output logic [RADDR_W-1:0]            debug_wb_rf_wnum,
    output logic [DATA_W-1:0]             debug_wb_rf_wdata
);
    localparam int OFF_W = $clog2(DATA_W/8);
    localparam int CNT_W = $clog2(TIMEOUT+1);

    typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} state_t;

    state_t              state, state_nxt;
    logic                capture;
    logic [1:0]          in_size;
    logic [OFF_W-1:0]    in_off;
    logic                in_mis;

    logic [31:0]         h_pc;
    logic                h_we;
    logic [RADDR_W-1:0]  h_waddr;
    logic [DATA_W-1:0]   h_data;
    logic [1:0]          h_size;
    logic                h_uns;
    logic [OFF_W-1:0]    h_off;
    logic [CNT_W-1:0]    cnt;

    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   ld_data;
    logic                wait_idle;

    assign in_allow  = (state == S_EMPTY) || (state == S_READY);
    assign capture   = in_valid && in_allow;
    assign wait_idle = (state == S_WAIT) && !mem_rvalid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_EMPTY;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY, S_READY: begin
                if (capture) state_nxt = in_is_load ? S_WAIT : S_READY;
                else         state_nxt = S_EMPTY;
            end
            S_WAIT:  if (mem_rvalid) state_nxt = S_READY;
            default: state_nxt = S_EMPTY;
        endcase
    end

    // Dword collapses to word on a 32-bit datapath; the offset is aligned once, at capture.
    always_comb begin
        in_size = in_ld_size;
        if (DATA_W == 32 && in_ld_size == 2'd3) in_size = 2'd2;
        in_off = in_addr_lo;
        in_mis = 1'b0;
        case (in_size)
            2'd0: ;
            2'd1: begin
                in_off[0] = 1'b0;
                in_mis    = in_addr_lo[0];
            end
            2'd2: begin
                in_off[1:0] = 2'b00;
                in_mis      = |in_addr_lo[1:0];
            end
            default: in_off = '0;
        endcase
    end

    assign shifted = mem_rdata >> {h_off, 3'b000};

    always_comb begin
        ld_data = shifted;
        case (h_size)
            2'd0: ld_data = h_uns ? DATA_W'(shifted[7:0])  : DATA_W'($signed(shifted[7:0]));
            2'd1: ld_data = h_uns ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
            2'd2: ld_data = h_uns ? DATA_W'(shifted[31:0]) : DATA_W'($signed(shifted[31:0]));
            default: ld_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_pc    <= '0;
            h_we    <= 1'b0;
            h_waddr <= '0;
            h_data  <= '0;
            h_size  <= 2'd0;
            h_uns   <= 1'b0;
            h_off   <= '0;
        end else if (capture) begin
            h_pc    <= in_pc;
            h_we    <= in_rf_we;
            h_waddr <= in_rf_waddr;
            h_data  <= in_alu_result;
            h_size  <= in_size;
            h_uns   <= in_ld_unsigned;
            h_off   <= in_off;
        end else if (state == S_WAIT && mem_rvalid) begin
            h_data  <= ld_data;
        end
    end

    // The load stays pending after a timeout; late data still retires normally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt          <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (capture) begin
                cnt <= '0;
            end else if (wait_idle && cnt != CNT_W'(TIMEOUT)) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (capture && in_is_load && in_mis)            err_misalign <= 1'b1;
            if (wait_idle && cnt == CNT_W'(TIMEOUT - 1))    err_timeout  <= 1'b1;
            if (mem_rvalid && state != S_WAIT)              err_spurious <= 1'b1;
        end
    end

    assign rf_we             = (state == S_READY) && h_we && (h_waddr != '0);
    assign rf_waddr          = h_waddr;
    assign rf_wdata          = h_data;
    assign byp_valid         = rf_we;
    assign byp_waddr         = h_waddr;
    assign byp_wdata         = h_data;
    assign byp_busy          = (state == S_WAIT) && h_we;
    assign debug_wb_pc       = h_pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = h_waddr;
    assign debug_wb_rf_wdata = h_data;

endmodule

// File: tb/tb_wb_stage_ldx.sv
// Bench for wb_stage_ldx: directed vector table, hand sequences for timeout/reset/spurious, random vs reference model.
module tb_wb_stage_ldx;
    localparam int TO = 4;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_allow, in_rf_we, in_is_load, in_ld_unsigned, mem_rvalid;
    logic [31:0] in_pc, in_alu_result, mem_rdata;
    logic [4:0]  in_rf_waddr;
    logic [1:0]  in_ld_size, in_addr_lo;
    logic        rf_we, byp_valid, byp_busy, err_misalign, err_timeout, err_spurious;
    logic [4:0]  rf_waddr, byp_waddr, debug_wb_rf_wnum;
    logic [31:0] rf_wdata, byp_wdata, debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_wen;

    int vectors = 0;
    int miscompares = 0;

    wb_stage_ldx #(.DATA_W(32), .RADDR_W(5), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_allow(in_allow),
        .in_pc(in_pc), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
        .in_alu_result(in_alu_result), .in_is_load(in_is_load), .in_ld_size(in_ld_size),
        .in_ld_unsigned(in_ld_unsigned), .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .byp_valid(byp_valid), .byp_waddr(byp_waddr), .byp_wdata(byp_wdata), .byp_busy(byp_busy),
        .err_misalign(err_misalign), .err_timeout(err_timeout), .err_spurious(err_spurious),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v; logic we; logic [4:0] wa; logic [31:0] alu; logic ld; logic [1:0] sz;
        logic un; logic [1:0] off; logic rv; logic [31:0] rd;
        logic e_allow; logic e_we; logic [4:0] e_wa; logic [31:0] e_wd;
        logic e_chkd; logic e_busy; logic e_mis;
    } vec_t;
    vec_t tbl[14];

    // reference model state: what instruction is held and whether its result is known yet
    logic        m_hold, m_have, m_we, m_mis, m_to, m_sp;
    logic [4:0]  m_waddr;
    logic [31:0] m_data, m_pc;
    logic [1:0]  m_sz, m_off;
    logic        m_un;
    int          m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_pc = 32'h0; in_rf_we = 1'b0; in_rf_waddr = 5'd0;
        in_alu_result = 32'h0; in_is_load = 1'b0; in_ld_size = 2'd0;
        in_ld_unsigned = 1'b0; in_addr_lo = 2'd0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    endtask

    function automatic int ref_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_extract(input logic [1:0] sz, input logic un,
                                                input logic [1:0] off, input logic [31:0] rd);
        int n, base;
        logic [31:0] v, mask;
        n    = ref_bytes(sz);
        base = (int'(off) / n) * n;
        v    = rd >> (8 * base);
        if (n == 4) return v;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v    = v & mask;
        if (!un && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic model_reset();
        m_hold = 1'b0; m_have = 1'b0; m_we = 1'b0; m_mis = 1'b0; m_to = 1'b0; m_sp = 1'b0;
        m_waddr = 5'd0; m_data = 32'h0; m_pc = 32'h0; m_sz = 2'd0; m_off = 2'd0; m_un = 1'b0;
        m_cnt = 0;
    endtask

    // advance the model by one clock using the inputs currently driven
    task automatic model_step();
        logic waiting;
        waiting = m_hold && !m_have;
        if (mem_rvalid && !waiting) m_sp = 1'b1;
        if (waiting) begin
            if (mem_rvalid) begin
                m_data = ref_extract(m_sz, m_un, m_off, mem_rdata);
                m_have = 1'b1;
            end else begin
                if (m_cnt < TO) m_cnt++;
                if (m_cnt == TO) m_to = 1'b1;
            end
        end else if (in_valid) begin
            m_hold = 1'b1; m_have = !in_is_load; m_we = in_rf_we; m_waddr = in_rf_waddr;
            m_data = in_alu_result; m_pc = in_pc; m_un = in_ld_unsigned; m_off = in_addr_lo;
            m_sz = in_ld_size; m_cnt = 0;
            if (in_is_load && (int'(in_addr_lo) % ref_bytes(in_ld_size)) != 0) m_mis = 1'b1;
        end else begin
            m_hold = 1'b0;
        end
    endtask

    task automatic cmp_model();
        logic e_we, waiting;
        waiting = m_hold && !m_have;
        e_we = m_hold && m_have && m_we && (m_waddr != 5'd0);
        chk("rnd_allow", 32'(in_allow), 32'(!waiting));
        chk("rnd_rf_we", 32'(rf_we), 32'(e_we));
        chk("rnd_rf_waddr", 32'(rf_waddr), 32'(m_waddr));
        chk("rnd_rf_wdata", rf_wdata, m_data);
        chk("rnd_byp_valid", 32'(byp_valid), 32'(e_we));
        chk("rnd_byp_waddr", 32'(byp_waddr), 32'(m_waddr));
        chk("rnd_byp_wdata", byp_wdata, m_data);
        chk("rnd_byp_busy", 32'(byp_busy), 32'(waiting && m_we));
        chk("rnd_err_misalign", 32'(err_misalign), 32'(m_mis));
        chk("rnd_err_timeout", 32'(err_timeout), 32'(m_to));
        chk("rnd_err_spurious", 32'(err_spurious), 32'(m_sp));
        chk("rnd_dbg_pc", debug_wb_pc, m_pc);
        chk("rnd_dbg_wen", 32'(debug_wb_rf_wen), 32'({4{e_we}}));
        chk("rnd_dbg_wnum", 32'(debug_wb_rf_wnum), 32'(m_waddr));
        chk("rnd_dbg_wdata", debug_wb_rf_wdata, m_data);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_allow"}, 32'(in_allow), 32'd1);
        chk({nm, "_rf_we"}, 32'(rf_we), 32'd0);
        chk({nm, "_rf_waddr"}, 32'(rf_waddr), 32'd0);
        chk({nm, "_rf_wdata"}, rf_wdata, 32'd0);
        chk({nm, "_byp_valid"}, 32'(byp_valid), 32'd0);
        chk({nm, "_byp_busy"}, 32'(byp_busy), 32'd0);
        chk({nm, "_errs"}, 32'({err_misalign, err_timeout, err_spurious}), 32'd0);
        chk({nm, "_dbg_pc"}, debug_wb_pc, 32'd0);
        chk({nm, "_dbg_wen"}, 32'(debug_wb_rf_wen), 32'd0);
    endtask

    initial begin
        //            v  we wa     alu             ld sz    un off   rv rd              allow we wa     wdata           chkd busy mis
        tbl[0]  = '{T, T, 5'd5,  32'h1234_5678, F, 2'd0, F, 2'd0, F, 32'h0,         T, T, 5'd5,  32'h1234_5678, T, F, F};
        tbl[1]  = '{F, F, 5'd0,  32'h0,         F, 2'd0, F, 2'd0, F, 32'h0,         T, F, 5'd5,  32'h1234_5678, T, F, F};
        tbl[2]  = '{T, T, 5'd7,  32'hAAAA_0001, F, 2'd0, F, 2'd0, F, 32'h0,         T, T, 5'd7,  32'hAAAA_0001, T, F, F};
        tbl[3]  = '{T, T, 5'd8,  32'h0000_0042, F, 2'd0, F, 2'd0, F, 32'h0,         T, T, 5'd8,  32'h0000_0042, T, F, F};
        tbl[4]  = '{T, T, 5'd0,  32'h0000_DEAD, F, 2'd0, F, 2'd0, F, 32'h0,         T, F, 5'd0,  32'h0000_DEAD, T, F, F};
        tbl[5]  = '{T, T, 5'd9,  32'h0,         T, 2'd0, F, 2'd2, F, 32'h0,         F, F, 5'd9,  32'h0,         F, T, F};
        tbl[6]  = '{F, F, 5'd0,  32'h0,         F, 2'd0, F, 2'd0, F, 32'h0,         F, F, 5'd9,  32'h0,         F, T, F};
        tbl[7]  = '{F, F, 5'd0,  32'h0,         F, 2'd0, F, 2'd0, F, 32'h0,         F, F, 5'd9,  32'h0,         F, T, F};
        tbl[8]  = '{F, F, 5'd0,  32'h0,         F, 2'd0, F, 2'd0, T, 32'h0080_0000, T, T, 5'd9,  32'hFFFF_FF80, T, F, F};
        tbl[9]  = '{T, T, 5'd10, 32'h0,         T, 2'd1, T, 2'd2, F, 32'h0,         F, F, 5'd10, 32'h0,         F, T, F};
        tbl[10] = '{F, F, 5'd0,  32'h0,         F, 2'd0, F, 2'd0, T, 32'h8001_0000, T, T, 5'd10, 32'h0000_8001, T, F, F};
        tbl[11] = '{T, T, 5'd11, 32'h0,         T, 2'd1, T, 2'd1, F, 32'h0,         F, F, 5'd11, 32'h0,         F, T, T};
        tbl[12] = '{F, F, 5'd0,  32'h0,         F, 2'd0, F, 2'd0, T, 32'h8001_0000, T, T, 5'd11, 32'h0000_0000, T, F, T};
        tbl[13] = '{F, F, 5'd0,  32'h0,         F, 2'd0, F, 2'd0, F, 32'h0,         T, F, 5'd11, 32'h0000_0000, T, F, T};

        idle_inputs();
        resetn = 1'b0;
        #2;
        chk_all_zero("reset");
        step(); step();
        resetn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            in_valid = tbl[i].v; in_rf_we = tbl[i].we; in_rf_waddr = tbl[i].wa;
            in_alu_result = tbl[i].alu; in_is_load = tbl[i].ld; in_ld_size = tbl[i].sz;
            in_ld_unsigned = tbl[i].un; in_addr_lo = tbl[i].off; mem_rvalid = tbl[i].rv;
            mem_rdata = tbl[i].rd; in_pc = 32'h1000 + 32'(i * 4);
            step();
            chk($sformatf("tbl%0d_allow", i), 32'(in_allow), 32'(tbl[i].e_allow));
            chk($sformatf("tbl%0d_rf_we", i), 32'(rf_we), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_byp_valid", i), 32'(byp_valid), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_rf_waddr", i), 32'(rf_waddr), 32'(tbl[i].e_wa));
            if (tbl[i].e_chkd) chk($sformatf("tbl%0d_rf_wdata", i), rf_wdata, tbl[i].e_wd);
            chk($sformatf("tbl%0d_byp_busy", i), 32'(byp_busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_err_misalign", i), 32'(err_misalign), 32'(tbl[i].e_mis));
        end
        idle_inputs();

        // timeout: load with no data, flag after exactly TO waiting cycles
        in_valid = 1'b1; in_is_load = 1'b1; in_rf_we = 1'b1; in_rf_waddr = 5'd3; in_ld_size = 2'd2;
        step();
        idle_inputs();
        chk("to_busy", 32'(byp_busy), 32'd1);
        chk("to_allow0", 32'(in_allow), 32'd0);
        chk("to_err0", 32'(err_timeout), 32'd0);
        for (int k = 1; k <= TO; k++) begin
            step();
            chk($sformatf("to_err_c%0d", k), 32'(err_timeout), 32'(k == TO));
            chk($sformatf("to_allow_c%0d", k), 32'(in_allow), 32'd0);
        end
        resetn = 1'b0;
        #1;
        chk_all_zero("to_reset");
        step();
        resetn = 1'b1;

        // data strobe with nothing outstanding
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_rvalid = 1'b0;
        chk("spur_flag", 32'(err_spurious), 32'd1);
        chk("spur_rf_we", 32'(rf_we), 32'd0);
        chk("spur_allow", 32'(in_allow), 32'd1);

        // reset in the middle of a pending load abandons it
        in_valid = 1'b1; in_is_load = 1'b1; in_rf_we = 1'b1; in_rf_waddr = 5'd4;
        step();
        idle_inputs();
        chk("mid_busy", 32'(byp_busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(byp_busy), 32'd0);
        chk("mid_rst_allow", 32'(in_allow), 32'd1);
        chk("mid_rst_spur", 32'(err_spurious), 32'd0);
        step();
        resetn = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_00FF;
        step();
        mem_rvalid = 1'b0;
        chk("mid_late_spur", 32'(err_spurious), 32'd1);
        chk("mid_late_we", 32'(rf_we), 32'd0);
        step();
        chk("mid_late_we2", 32'(rf_we), 32'd0);

        // randomized traffic against the reference model
        resetn = 1'b0;
        #1;
        model_reset();
        step();
        resetn = 1'b1;
        for (int c = 0; c < 600; c++) begin
            in_valid       = ($urandom_range(0, 99) < 55);
            in_pc          = $urandom;
            in_rf_we       = ($urandom_range(0, 99) < 80);
            in_rf_waddr    = 5'($urandom_range(0, 31));
            in_alu_result  = $urandom;
            in_is_load     = ($urandom_range(0, 99) < 45);
            in_ld_size     = 2'($urandom_range(0, 3));
            in_ld_unsigned = 1'($urandom_range(0, 1));
            in_addr_lo     = 2'($urandom_range(0, 3));
            mem_rvalid     = ($urandom_range(0, 99) < 35);
            mem_rdata      = $urandom;
            model_step();
            step();
            cmp_model();
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
